multdiv_ctrl: RTL
=================

# multdiv_ctrl

Sequencing controller that sits between the CPU execute stage and the `multdiv` unit. It accepts one multiply or divide operation at a time and latches its operands and destination register. It pulses `ctrl_MULT`/`ctrl_DIV` for exactly one cycle and stalls the pipeline until `data_resultRDY` arrives. It then presents the result for writeback under a valid/ack handshake and protects the pipeline from a hung unit with a watchdog timeout.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `RD_W`, 5, destination-register tag width
- `TIMEOUT`, 64, maximum cycles spent in BUSY before abort (≥2)

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `issue_valid`  in  1  execute stage presents a mult/div op
- `issue_is_div`  in  1  1 = divide, 0 = multiply
- `issue_a`, `issue_b`  in  WIDTH  operands A, B
- `issue_rd`  in  RD_W  destination register
- `issue_ready`  out  1  controller can accept an op (state IDLE)
- `stall`  out  1  pipeline freeze; high whenever state ≠ IDLE
- `md_operandA`, `md_operandB`  out  WIDTH  to multdiv `data_operandA/B`
- `md_ctrl_MULT`, `md_ctrl_DIV`  out  1  to multdiv start inputs
- `md_reset`  out  1  reset to multdiv datapath
- `md_result`  in  WIDTH  from multdiv `data_result`
- `md_exception`  in  1  from multdiv `data_exception`
- `md_resultRDY`  in  1  from multdiv `data_resultRDY`
- `wb_valid`  out  1  writeback result available
- `wb_rd`  out  RD_W  destination tag
- `wb_data`  out  WIDTH  result
- `wb_exception`  out  1  overflow / div-by-zero / timeout
- `wb_ack`  in  1  writeback consumed
- `timeout_err`  out  1  sticky; set on any watchdog abort

## Operation
- FSM states: IDLE, START, BUSY, DONE.
- IDLE: `issue_ready`=1. When `issue_valid`=1, latch a, b, is_div, rd into op registers; next state START.
- START: `md_ctrl_MULT`=!is_div, `md_ctrl_DIV`=is_div for this single cycle only. Clear the watchdog counter. Ignore `md_resultRDY` (stale from previous op). Next state BUSY.
- BUSY: if `md_resultRDY`=1, capture `md_result`→`wb_data` and `md_exception`→`wb_exception`; next state DONE. Otherwise increment the counter. If counter = TIMEOUT−1 and no RDY: `wb_data`=0, `wb_exception`=1, set `timeout_err`, pulse `md_reset` for one cycle; next state DONE. RDY in the timeout cycle wins (normal capture, no abort).
- DONE: `wb_valid`=1; `wb_rd`/`wb_data`/`wb_exception` held stable. On `wb_ack`=1 go to IDLE. `issue_valid` is ignored in DONE; there is no same-cycle re-issue.
- `md_operandA/B` are driven from the op registers. They are stable from START through the end of BUSY.
- Div-by-zero and overflow are not detected locally; they pass through from `md_exception`.
- `wb_ack` outside DONE is ignored. `issue_*` inputs outside IDLE are ignored.
- `md_reset` = `reset` OR the registered timeout pulse.

## Timing
- Reset (async assert, sync deassert use): state IDLE. All outputs 0 except `issue_ready`=1. Op and wb registers 0. `timeout_err`=0. Counter 0.
- Reset mid-operation (any state): immediate return to IDLE. `md_ctrl_*`, `wb_valid`, `stall` go low. `md_reset` is high for the duration of reset.
- Issue accepted at edge T → START in cycle T+1 (start pulse) → BUSY from T+2.
- RDY sampled high in BUSY at edge E → `wb_valid`=1 from E+1.
- Ack at edge D → IDLE and `issue_ready`=1 from D+1.
- Minimum issue-to-issue interval: 4 cycles (RDY on first BUSY cycle, immediate ack).
- Watchdog: at most TIMEOUT cycles in BUSY. Abort is visible as `wb_valid`=1 on the cycle after the TIMEOUT-th BUSY cycle.
- The counter is wide enough for TIMEOUT−1 with no wrap.
- All outputs are registered or decoded from state only, with no combinational path from `md_*` inputs, with one exception: `md_reset` from `reset`.

## Test plan
- Mult 7×6, rd=3, RDY after 17 BUSY cycles: exactly one `md_ctrl_MULT` pulse, `md_ctrl_DIV` never high, `stall` high throughout. Then `wb_valid`, `wb_data`=42, `wb_rd`=3, `wb_exception`=0; `issue_ready` back one cycle after ack.
- Div 100÷7 with RDY asserted during START and again in BUSY: START-cycle RDY ignored; `md_ctrl_DIV` pulses once; `wb_data`=14.
- Div 5÷0, unit returns exception=1, result=0: `wb_exception`=1, `timeout_err`=0.
- TIMEOUT=64, RDY never asserted: exactly 64 BUSY cycles; `md_reset` high one cycle; `wb_data`=0, `wb_exception`=1, `timeout_err`=1 and still 1 after the next successful op.
- `wb_ack` held low 5 cycles in DONE while `issue_valid`=1 with new operands: `wb_*` stable, `issue_ready`=0, no new start pulse; new op accepted only after ack.
- `reset` asserted on BUSY cycle 3: all outputs drop to reset values immediately, `md_reset`=1. A subsequent mult 3×3 yields 9.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one multiply/divide at a time through the multdiv unit.
// Latency: issue edge T -> start pulse in T+1 -> BUSY from T+2; wb_valid the cycle after RDY or abort.
// Backpressure: stall is high and issue_ready low outside IDLE; the result is held until wb_ack.
//
// Ports:
//   clock, reset           - rising-edge clock, async active-high reset
//   issue_*                - op from execute stage (valid, is_div, a, b, rd); issue_ready/stall back
//   md_operandA/B, md_ctrl_MULT/DIV, md_reset - drive the multdiv unit
//   md_result, md_exception, md_resultRDY     - results from the multdiv unit
//   wb_valid/rd/data/exception, wb_ack        - writeback handshake
//   timeout_err            - sticky flag, set on any watchdog abort
module multdiv_ctrl #(
    parameter int WIDTH   = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             issue_valid,
    input  logic             issue_is_div,
    input  logic [WIDTH-1:0] issue_a,
    input  logic [WIDTH-1:0] issue_b,
    input  logic [RD_W-1:0]  issue_rd,
    output logic             issue_ready,
    output logic             stall,

    output logic [WIDTH-1:0] md_operandA,
    output logic [WIDTH-1:0] md_operandB,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    output logic             md_reset,
    input  logic [WIDTH-1:0] md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,

    output logic             wb_valid,
    output logic [RD_W-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_exception,
    input  logic             wb_ack,

    output logic             timeout_err
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits never wrap.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;

    // Operand/tag registers: written only in IDLE, so they stay stable
    // from START through DONE and double as the writeback tag.
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_is_div;
    logic [RD_W-1:0]    op_rd;

    logic [CNT_W-1:0]   wd_cnt;
    logic [WIDTH-1:0]   res_data;
    logic               res_exc;
    logic               terr;
    logic               abort_pulse;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_is_div   <= 1'b0;
            op_rd       <= '0;
            wd_cnt      <= '0;
            res_data    <= '0;
            res_exc     <= 1'b0;
            terr        <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            // The abort reset to the unit lasts exactly one cycle.
            abort_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue_valid) begin
                        op_a      <= issue_a;
                        op_b      <= issue_b;
                        op_is_div <= issue_is_div;
                        op_rd     <= issue_rd;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    // md_resultRDY may still be high from the previous op here;
                    // it is deliberately not looked at in this state.
                    wd_cnt <= '0;
                    state  <= S_BUSY;
                end
                S_BUSY: begin
                    if (md_resultRDY) begin
                        // A result arriving in the last allowed cycle beats the abort.
                        res_data <= md_result;
                        res_exc  <= md_exception;
                        state    <= S_DONE;
                    end else if (wd_cnt == CNT_MAX) begin
                        res_data    <= '0;
                        res_exc     <= 1'b1;
                        terr        <= 1'b1;
                        abort_pulse <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (wb_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs below are decoded from registered state; the only
    // combinational input path is reset into md_reset.
    assign issue_ready  = (state == S_IDLE);
    assign stall        = (state != S_IDLE);

    assign md_operandA  = op_a;
    assign md_operandB  = op_b;
    assign md_ctrl_MULT = (state == S_START) & ~op_is_div;
    assign md_ctrl_DIV  = (state == S_START) &  op_is_div;
    assign md_reset     = reset | abort_pulse;

    assign wb_valid     = (state == S_DONE);
    assign wb_rd        = op_rd;
    assign wb_data      = res_data;
    assign wb_exception = res_exc;

    assign timeout_err  = terr;

endmodule
